number_entry: RTL

Keypad number-entry stage that sits directly upstream of the 6-digit seven-segment driver. It accumulates decimal key presses into a signed value and handles sign toggle, backspace and clear. It also accepts loads of externally computed results. It produces the 32-bit `fnd_serial` word the driver decodes: a two's-complement number, or the driver's special codes for "no entry" and "error".

---
 rtl/number_entry.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/number_entry.sv
// Keypad number-entry stage: accumulates decimal keys into a signed value and
// emits the 32-bit word consumed by the six-digit seven-segment driver.
module number_entry #(
  parameter int MAX_DIGITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        load_valid,
  input  logic [31:0] load_value,
  output logic [31:0] fnd_serial,
  output logic [31:0] value,
  output logic        value_valid,
  output logic [2:0]  digit_cnt,
  output logic        err
);

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] dec_digits(input logic [19:0] m);
    if (m < 20'd10) begin
      return 3'd1;
    end else if (m < 20'd100) begin
      return 3'd2;
    end else if (m < 20'd1000) begin
      return 3'd3;
    end else if (m < 20'd10000) begin
      return 3'd4;
    end else if (m < 20'd100000) begin
      return 3'd5;
    end else begin
      return 3'd6;
    end
  endfunction

  localparam logic [31:0] POS_LIM = 32'(pow10(MAX_DIGITS) - 1);
  localparam logic [31:0] NEG_LIM = 32'(pow10(MAX_DIGITS - 1) - 1);
  localparam logic [2:0]  MAX_CNT = 3'(MAX_DIGITS);
  localparam logic [31:0] CODE_EMPTY = 32'h00CC_0000;
  localparam logic [31:0] CODE_ERROR = 32'h00EE_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [31:0] fnd_serial_d, value_d;
  logic        value_valid_d, err_d;
  logic [31:0] fnd_serial_q, value_q;
  logic        value_valid_q, err_q;

  logic [31:0] ld_abs_s;
  logic        ld_in_range_s;
  logic [2:0]  dig_lim_s;

  // Magnitude of the load and its range check; the abs value of 0x8000_0000 stays huge, so it lands out of range.
  always_comb begin
    ld_abs_s      = load_value[31] ? (32'd0 - load_value) : load_value;
    ld_in_range_s = load_value[31] ? (ld_abs_s <= NEG_LIM) : (ld_abs_s <= POS_LIM);
    dig_lim_s     = neg_q ? (MAX_CNT - 3'd1) : MAX_CNT;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      mag_q   <= 20'd0;
      neg_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a load takes priority over a key arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    if (load_valid) begin
      if (ld_in_range_s) begin
        state_d = ST_ENTRY;
        neg_d   = load_value[31];
        mag_d   = ld_abs_s[19:0];
        cnt_d   = dec_digits(ld_abs_s[19:0]);
      end else begin
        state_d = ST_ERROR;
        mag_d   = 20'd0;
        neg_d   = 1'b0;
        cnt_d   = 3'd0;
      end
    end else if (key_valid) begin
      if (key_code == 4'hC) begin
        state_d = ST_EMPTY;
        mag_d   = 20'd0;
        neg_d   = 1'b0;
        cnt_d   = 3'd0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (key_code <= 4'd9) begin
              state_d = ST_ENTRY;
              mag_d   = {16'd0, key_code};
              neg_d   = 1'b0;
              cnt_d   = 3'd1;
            end else begin
              state_d = ST_EMPTY;
            end
          end
          ST_ENTRY: begin
            if (key_code <= 4'd9) begin
              if (mag_q == 20'd0) begin
                mag_d = {16'd0, key_code};
              end else if (cnt_q < dig_lim_s) begin
                mag_d = mag_q * 20'd10 + {16'd0, key_code};
                cnt_d = cnt_q + 3'd1;
              end else begin
                mag_d = mag_q;
              end
            end else if (key_code == 4'hA) begin
              if ((mag_q != 20'd0) && !(!neg_q && (cnt_q == MAX_CNT))) begin
                neg_d = ~neg_q;
              end else begin
                neg_d = neg_q;
              end
            end else if (key_code == 4'hB) begin
              if (cnt_q == 3'd1) begin
                state_d = ST_EMPTY;
                mag_d   = 20'd0;
                neg_d   = 1'b0;
                cnt_d   = 3'd0;
              end else begin
                mag_d = mag_q / 20'd10;
                cnt_d = cnt_q - 3'd1;
              end
            end else begin
              state_d = ST_ENTRY;
            end
          end
          ST_ERROR: state_d = ST_ERROR;
          default: begin
            state_d = ST_EMPTY;
            mag_d   = 20'd0;
            neg_d   = 1'b0;
            cnt_d   = 3'd0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output values derived from the next state so they register alongside it.
  always_comb begin
    value_d       = neg_d ? (32'd0 - {12'd0, mag_d}) : {12'd0, mag_d};
    value_valid_d = 1'b0;
    err_d         = 1'b0;
    case (state_d)
      ST_EMPTY: fnd_serial_d = CODE_EMPTY;
      ST_ENTRY: begin
        fnd_serial_d  = value_d;
        value_valid_d = 1'b1;
      end
      ST_ERROR: begin
        fnd_serial_d = CODE_ERROR;
        err_d        = 1'b1;
      end
      default: fnd_serial_d = CODE_EMPTY;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fnd_serial_q  <= CODE_EMPTY;
      value_q       <= 32'd0;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      fnd_serial_q  <= fnd_serial_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      err_q         <= err_d;
    end
  end

  assign fnd_serial  = fnd_serial_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign digit_cnt   = cnt_q;
  assign err         = err_q;

endmodule
